// File: rtl/lo_seq_pkg.sv
// rtl/lo_seq_pkg.sv - shared constants, LO phase-select code table and FSM states for the LO channel sequencer
package lo_seq_pkg;

    localparam int N_CHAN = 20;
    localparam int CODE_W = 6;
    localparam int CHAN_W = 5;

    // Selects no channel on the downstream one-hot decoder.
    localparam logic [CODE_W-1:0] IDLE_CODE = 6'h00;

    localparam logic [CODE_W-1:0] CODE_TABLE [N_CHAN] = '{
        6'h03, 6'h02, 6'h06, 6'h0D, 6'h0F, 6'h0B, 6'h19, 6'h1F, 6'h1C, 6'h10,
        6'h30, 6'h3C, 6'h3F, 6'h39, 6'h2B, 6'h2F, 6'h2D, 6'h26, 6'h22, 6'h23
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        DWELL = 2'd2
    } state_t;

endpackage

// File: rtl/lo_next_chan.sv
// rtl/lo_next_chan.sv - finds the next enabled channel above the current one and the lowest enabled channel
import lo_seq_pkg::*;

module lo_next_chan (
    input  logic [N_CHAN-1:0] mask,
    input  logic [CHAN_W-1:0] cur,
    output logic [CHAN_W-1:0] next_idx,
    output logic [CHAN_W-1:0] low_idx,
    output logic              none_above
);

    // Scan from the top down so the last hit is the smallest qualifying index.
    always_comb begin
        next_idx   = '0;
        low_idx    = '0;
        none_above = 1'b1;
        for (int i = N_CHAN - 1; i >= 0; i--) begin
            if (mask[i]) begin
                low_idx = CHAN_W'(i);
                if (CHAN_W'(i) > cur) begin
                    next_idx   = CHAN_W'(i);
                    none_above = 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/lo_chan_sequencer.sv
// rtl/lo_chan_sequencer.sv - steps the LO phase-select code through enabled channels; LO_SEQ_GAP_EN adds break-before-make idle gaps
import lo_seq_pkg::*;

module lo_chan_sequencer #(
    parameter int DWELL_W    = 16,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic               continuous_i,
    input  logic [N_CHAN-1:0]  chan_mask_i,
    input  logic [DWELL_W-1:0] dwell_i,
    output logic [CODE_W-1:0]  code_o,
    output logic [CHAN_W-1:0]  chan_o,
    output logic               busy_o,
    output logic               step_o,
    output logic               sweep_done_o
);

    state_t              state_q, state_d;
    logic [CHAN_W-1:0]   chan_q, chan_d, tgt;
    logic [DWELL_W-1:0]  cnt_q, cnt_d, dwell_q, dwell_d;
    logic [N_CHAN-1:0]   mask_q, mask_d, scan_mask;
    logic [CODE_W-1:0]   code_q, code_d;
    logic                cont_q, cont_d, step_q, step_d;
    logic                enter, sweep_done;
    logic [CHAN_W-1:0]   next_idx, low_idx;
    logic                none_above;

`ifdef LO_SEQ_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    // While idle the lowest channel comes from the live mask so it can be driven one cycle after start.
    assign scan_mask = (state_q == IDLE) ? chan_mask_i : mask_q;

    lo_next_chan u_next_chan (
        .mask       (scan_mask),
        .cur        (chan_q),
        .next_idx   (next_idx),
        .low_idx    (low_idx),
        .none_above (none_above)
    );

    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        mask_d     = mask_q;
        dwell_d    = dwell_q;
        cont_d     = cont_q;
        code_d     = code_q;
        step_d     = 1'b0;
        enter      = 1'b0;
        tgt        = chan_q;
        sweep_done = 1'b0;
`ifdef LO_SEQ_GAP_EN
        gap_d      = gap_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_i && (chan_mask_i != '0)) begin
                    mask_d  = chan_mask_i;
                    dwell_d = dwell_i;
                    cont_d  = continuous_i;
                    enter   = 1'b1;
                    tgt     = low_idx;
                end
            end
            DWELL: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!none_above) begin
                    enter = 1'b1;
                    tgt   = next_idx;
                end else begin
                    sweep_done = 1'b1;
                    if (cont_q) begin
                        enter = 1'b1;
                        tgt   = low_idx;
                    end else begin
                        state_d = IDLE;
                        chan_d  = '0;
                        code_d  = IDLE_CODE;
                    end
                end
            end
`ifdef LO_SEQ_GAP_EN
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else begin
                    state_d = DWELL;
                    code_d  = CODE_TABLE[chan_q];
                    step_d  = 1'b1;
                    cnt_d   = dwell_q;
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        if (enter) begin
            chan_d = tgt;
`ifdef LO_SEQ_GAP_EN
            state_d = GAP;
            code_d  = IDLE_CODE;
            gap_d   = GAP_LOAD;
`else
            state_d = DWELL;
            code_d  = CODE_TABLE[tgt];
            step_d  = 1'b1;
            cnt_d   = dwell_d;
`endif
        end

        // Abort wins over everything, including a same-cycle start or sweep completion.
        if (stop_i) begin
            state_d    = IDLE;
            chan_d     = '0;
            cnt_d      = '0;
            code_d     = IDLE_CODE;
            step_d     = 1'b0;
            sweep_done = 1'b0;
            mask_d     = mask_q;
            dwell_d    = dwell_q;
            cont_d     = cont_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            chan_q  <= '0;
            cnt_q   <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
            cont_q  <= 1'b0;
            code_q  <= IDLE_CODE;
            step_q  <= 1'b0;
`ifdef LO_SEQ_GAP_EN
            gap_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            chan_q  <= chan_d;
            cnt_q   <= cnt_d;
            mask_q  <= mask_d;
            dwell_q <= dwell_d;
            cont_q  <= cont_d;
            code_q  <= code_d;
            step_q  <= step_d;
`ifdef LO_SEQ_GAP_EN
            gap_q   <= gap_d;
`endif
        end
    end

    assign code_o       = code_q;
    assign chan_o       = chan_q;
    assign busy_o       = (state_q != IDLE);
    assign step_o       = step_q;
    assign sweep_done_o = sweep_done;

endmodule
